// File: rtl/fsk8_pkg.sv
// Shared types and helpers for the 8-FSK discriminator demodulator.
//   fsk8_state_t : symbol-timing FSM states
//   SYM_W/NUM_THR: symbol width and number of slicer thresholds
//   fsk8_slice   : maps an integrated discriminator value onto a symbol 0..7
package fsk8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DUMP = 2'd2
    } fsk8_state_t;

    localparam int unsigned SYM_W   = 3;
    localparam int unsigned NUM_THR = 7;

    // Symbol = number of thresholds T_k = (k-3)*step that d strictly exceeds.
    function automatic logic [SYM_W-1:0] fsk8_slice(input logic signed [63:0] d,
                                                    input logic signed [63:0] step);
        logic [SYM_W-1:0] n;
        n = '0;
        for (int k = 0; k < int'(NUM_THR); k++) begin
            if (d > ((64'(k) - 64'sd3) * step)) begin
                n = n + SYM_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fsk8_xprod.sv
// Two-stage cross-product pipeline: stage 1 holds current/previous I/Q sample,
// stage 2 registers p = I_prev*Q - Q_prev*I at full precision.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               drop in-flight samples/products and forget the previous sample
//   in_valid/in_last    sample strobe and end-of-symbol tag
//   in_i, in_q          signed I/Q sample
//   p_valid/p_last      product strobe and tag (registered)
//   p                   signed product, 2*DATA_W+1 bits (registered)
module fsk8_xprod #(
    parameter int unsigned DATA_W = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic signed [DATA_W-1:0] in_q,
    output logic                     p_valid,
    output logic                     p_last,
    output logic signed [2*DATA_W:0] p
);

    localparam int unsigned MW = 2 * DATA_W;
    localparam int unsigned PW = 2 * DATA_W + 1;

    logic signed [DATA_W-1:0] cur_i, cur_q, prv_i, prv_q;
    logic                     have_cur;
    logic                     s1_valid, s1_pv, s1_last;
    logic signed [MW-1:0]     m1_c, m2_c;
    logic signed [PW-1:0]     diff_c;

    // Full-precision multiply-subtract on the stage-1 pair.
    always_comb begin
        m1_c   = MW'(prv_i) * MW'(cur_q);
        m2_c   = MW'(prv_q) * MW'(cur_i);
        diff_c = PW'(m1_c) - PW'(m2_c);
    end

    // A sample taken together with flush starts fresh, so its product is masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_i    <= '0;
            cur_q    <= '0;
            prv_i    <= '0;
            prv_q    <= '0;
            have_cur <= 1'b0;
            s1_valid <= 1'b0;
            s1_pv    <= 1'b0;
            s1_last  <= 1'b0;
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            p        <= '0;
        end else begin
            if (in_valid) begin
                cur_i   <= in_i;
                cur_q   <= in_q;
                prv_i   <= cur_i;
                prv_q   <= cur_q;
                s1_pv   <= have_cur & ~flush;
                s1_last <= in_last;
            end
            s1_valid <= in_valid;
            if (flush) begin
                have_cur <= in_valid;
            end else if (in_valid) begin
                have_cur <= 1'b1;
            end
            p_valid <= s1_valid & ~flush;
            if (s1_valid && !flush) begin
                p      <= s1_pv ? diff_c : '0;
                p_last <= s1_last;
            end
        end
    end

endmodule

// File: rtl/fsk8_disc_demod.sv
// 8-FSK symbol detector: cross-product frequency discriminator integrated over
// SPS accepted samples, sliced into 8 levels with spacing STEP.
// Optional feature macro: FSK8_SOFT_OUT_EN (defined: disc_out carries the
// integrated value; undefined: disc_out is tied to 0 and has no register).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_valid       sample strobe for input_1 (I) / input_2 (Q)
//   sync           one-cycle pulse restarting symbol alignment
//   sym_valid      one-cycle strobe per symbol decision
//   sym_out        decided symbol 0..7
//   disc_out       integrated discriminator value of the reported symbol
//   sat            accumulator clipped during the reported symbol
module fsk8_disc_demod
    import fsk8_pkg::*;
#(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned SPS    = 16,
    parameter int unsigned ACC_W  = 48,
    parameter int unsigned STEP   = 1048576
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] input_1,
    input  logic signed [DATA_W-1:0] input_2,
    input  logic                     sync,
    output logic                     sym_valid,
    output logic [SYM_W-1:0]         sym_out,
    output logic signed [ACC_W-1:0]  disc_out,
    output logic                     sat
);

    localparam int unsigned PW    = 2 * DATA_W + 1;
    localparam int unsigned SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam int unsigned CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

    logic [CNT_W-1:0]       cnt;
    logic                   last_c;
    logic                   x_valid, x_last;
    logic signed [PW-1:0]   x_p;
    fsk8_state_t            state, state_nxt;
    logic                   dump_c;
    logic signed [ACC_W-1:0] acc, acc_nxt_c;
    logic                   sat_int, clip_c;
    logic signed [SUM_W-1:0] base_c, sum_c;

    // Accepted-sample counter; the SPS-th sample of a symbol carries the last tag.
    assign last_c = in_valid & ~sync & (cnt == CNT_W'(SPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sync) begin
            cnt <= in_valid ? CNT_W'(1) : '0;
        end else if (in_valid) begin
            cnt <= last_c ? '0 : cnt + CNT_W'(1);
        end
    end

    fsk8_xprod #(
        .DATA_W (DATA_W)
    ) u_xprod (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (sync),
        .in_valid (in_valid),
        .in_last  (last_c),
        .in_i     (input_1),
        .in_q     (input_2),
        .p_valid  (x_valid),
        .p_last   (x_last),
        .p        (x_p)
    );

    // Symbol-timing FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: DUMP follows the edge that integrates the tagged last product.
    always_comb begin
        state_nxt = state;
        dump_c    = 1'b0;
        case (state)
            IDLE: begin
                if (x_valid && x_last) begin
                    state_nxt = DUMP;
                end else if (in_valid) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (x_valid && x_last) begin
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                dump_c    = 1'b1;
                state_nxt = ACC;
            end
            default: state_nxt = IDLE;
        endcase
        if (sync) begin
            state_nxt = IDLE;
        end
    end

    // Saturating add; in DUMP the new product starts the next symbol from zero.
    always_comb begin
        base_c = dump_c ? '0 : SUM_W'(acc);
        sum_c  = base_c + SUM_W'(x_p);
        clip_c = 1'b0;
        if (sum_c > ACC_MAX) begin
            acc_nxt_c = ACC_W'(ACC_MAX);
            clip_c    = 1'b1;
        end else if (sum_c < ACC_MIN) begin
            acc_nxt_c = ACC_W'(ACC_MIN);
            clip_c    = 1'b1;
        end else begin
            acc_nxt_c = ACC_W'(sum_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            sat_int <= 1'b0;
        end else if (sync) begin
            acc     <= '0;
            sat_int <= 1'b0;
        end else if (x_valid) begin
            acc     <= acc_nxt_c;
            sat_int <= (dump_c ? 1'b0 : sat_int) | clip_c;
        end else if (dump_c) begin
            acc     <= '0;
            sat_int <= 1'b0;
        end
    end

    // Decision registers; they hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_valid <= 1'b0;
            sym_out   <= '0;
            sat       <= 1'b0;
        end else begin
            sym_valid <= dump_c;
            if (dump_c) begin
                sym_out <= fsk8_slice(64'(acc), 64'(STEP));
                sat     <= sat_int;
            end
        end
    end

`ifdef FSK8_SOFT_OUT_EN
    logic signed [ACC_W-1:0] disc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disc_q <= '0;
        end else if (dump_c) begin
            disc_q <= acc;
        end
    end

    assign disc_out = disc_q;
`else
    assign disc_out = '0;
`endif

endmodule

// File: doc/fsk8_disc_demod.md
Name: fsk8_disc_demod

Overview:
- Receive-side 8-FSK symbol detector. It sits directly after the channel/noise stage and consumes the noisy 18-bit signed I/Q stream.
- Computes a per-sample cross-product frequency discriminator (I[n-1]·Q[n] − Q[n-1]·I[n]) and integrates it over one symbol period.
- Slices the integrated value into one of 8 symbols and emits one symbol per SPS accepted samples, with a valid strobe.

Parameters:
- DATA_W, 18: I/Q sample width, signed.
- SPS, 16: samples per symbol, range 2..256.
- ACC_W, 48: discriminator accumulator width, signed.
- STEP, 1048576: slicer threshold spacing. Thresholds T_k = (k−3)·STEP, k=0..6.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe; input_1/input_2 are sampled only when high.
- input_1  in  DATA_W  I sample, signed.
- input_2  in  DATA_W  Q sample, signed.
- sync  in  1  one-cycle pulse that restarts symbol alignment.
- sym_valid  out  1  one-cycle strobe for a new symbol decision.
- sym_out  out  3  decided symbol, 0..7.
- disc_out  out  ACC_W  integrated discriminator value, signed.
- sat  out  1  accumulator saturated during the symbol just reported.

Behaviour:
- Reset (async, rst_n=0): sym_valid=0, sym_out=0, disc_out=0, sat=0. Sample counter=0, prev_valid=0, accumulator=0, pipeline valids=0, FSM=IDLE.
- Stage 1, on in_valid: register current sample; previous sample := old current; prev_valid set after the first accepted sample.
- Stage 2: product p = I_prev·Q − Q_prev·I, full precision 2·DATA_W+1 bits. p is forced to 0 when prev_valid=0 (first sample after reset or sync).
- Stage 3: accumulator += sign-extended p, saturating at ±(2^(ACC_W−1)−1). Any clip sets a sticky sat_int for the current symbol.
- FSM states:
  - IDLE: waits for the first in_valid → ACC.
  - ACC: counts accepted samples 0..SPS−1. When the SPS-th sample's product reaches stage 3 → DUMP.
  - DUMP: one cycle. Registers disc_out := final accumulator value, sat := sat_int, sym_out := count of k with D > T_k, and pulses sym_valid. Accumulator and sat_int are cleared; if a product arrives in the same cycle, the accumulator is loaded with it instead. Next state is ACC.
- Latency: sym_valid rises exactly 3 clk cycles after the clock edge that accepts the SPS-th in_valid sample.
- Gaps in in_valid: the pipeline stalls per stage via valid bits. Counts advance only on accepted samples, so the decision is unaffected by gaps.
- Back-to-back in_valid at full rate is sustained with no bubble at symbol boundaries.
- The previous sample carries across symbol boundaries; only reset and sync clear prev_valid.
- sync: clears counter, accumulator, sat_int and prev_valid, and flushes in-flight products; FSM → IDLE.
  - A symbol whose DUMP coincides with sync is still reported.
  - An in_valid in the same cycle as sync is accepted as the first sample of the new symbol.
- Outputs hold their values between sym_valid pulses.
- Reset mid-symbol: all partial state is discarded and no symbol is emitted.

Optional Feature:
- Macro FSK8_SOFT_OUT_EN.
- Defined: disc_out carries the integrated value as described above.
- Undefined: disc_out is driven constant 0 and its register is removed. sym_out, sym_valid and sat are unchanged.

Decomposition:
- Shared package fsk8_pkg holds:
  - the FSM state enum (IDLE, ACC, DUMP);
  - SYM_W=3 and NUM_THR=7;
  - a function that slices a signed ACC_W value against thresholds T_k.
- One sub-module, fsk8_xprod: a pipelined cross-product stage (registered multiply-subtract with valid passthrough and prev_valid masking).

Test Plan:
1. +90° rotation, A=1000, samples (1000,0),(0,1000),(−1000,0),(0,−1000) repeated, in_valid continuous, SPS=16 → first symbol D=15,000,000, sym_out=7; later symbols D=16,000,000, sym_out=7. sym_valid pulses every 16 cycles, first at cycle 3 after the 16th sample.
2. −90° rotation, same amplitude → D=−16,000,000 (steady state), sym_out=0.
3. Constant input (1000,0) → D=0, sym_out=3, sat=0.
4. Slice boundaries, by forcing products so that D = STEP+1 and then D = STEP → sym_out=5 and sym_out=4 respectively.
5. Saturation with ACC_W=32: full-scale ±131071 samples rotating +90° → sat=1 and disc_out=2^31−1; the next small-signal symbol reports sat=0.
6. in_valid gaps every other cycle, plus a sync pulse after sample 7 → no symbol until 16 new samples; the first product after sync is zero. Asserting rst_n=0 mid-symbol drops all outputs to 0 immediately.
